// File: rtl/intensity_pkg.sv
// Shared types and arithmetic constants for the RGB->intensity window converter.
package intensity_pkg;

    typedef enum logic [1:0] {
        MODE_AVG  = 2'd0,
        MODE_LUMA = 2'd1,
        MODE_MAX  = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam int LUMA_R  = 77;
    localparam int LUMA_G  = 150;
    localparam int LUMA_B  = 29;
    localparam int AVG_MUL = 683;
    localparam int AVG_SH  = 11;
    localparam int LUMA_SH = 8;

    // Raw mode encoding 2'b11 is an alias of AVG.
    function automatic mode_t decode_mode(input logic [1:0] raw);
        mode_t m;
        case (raw)
            2'b01:   m = MODE_LUMA;
            2'b10:   m = MODE_MAX;
            default: m = MODE_AVG;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/intensity_lane.sv
// Combinational single-pixel RGB->intensity converter (AVG / LUMA / MAX) with saturation.
module intensity_lane
    import intensity_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic [3*PIX_W-1:0] pix,
    input  mode_t              mode,
    output logic [PIX_W-1:0]   y
);

    localparam int IW = PIX_W + 11;

    logic [PIX_W-1:0] r_s, g_s, b_s, max_s;
    logic [IW-1:0]    r_e_s, g_e_s, b_e_s, res_s;

    assign r_s   = pix[3*PIX_W-1 -: PIX_W];
    assign g_s   = pix[2*PIX_W-1 -: PIX_W];
    assign b_s   = pix[PIX_W-1 -: PIX_W];
    assign r_e_s = IW'(r_s);
    assign g_e_s = IW'(g_s);
    assign b_e_s = IW'(b_s);

    // Largest of the three channels.
    always_comb begin
        max_s = r_s;
        if (g_s > max_s) begin
            max_s = g_s;
        end else begin
            max_s = max_s;
        end
        if (b_s > max_s) begin
            max_s = b_s;
        end else begin
            max_s = max_s;
        end
    end

    // Mode-dependent arithmetic, then clamp anything wider than PIX_W.
    always_comb begin
        res_s = '0;
        case (mode)
            MODE_LUMA: res_s = (r_e_s * IW'(LUMA_R) + g_e_s * IW'(LUMA_G)
                                + b_e_s * IW'(LUMA_B)) >> LUMA_SH;
            MODE_MAX:  res_s = IW'(max_s);
            default:   res_s = ((r_e_s + g_e_s + b_e_s) * IW'(AVG_MUL)) >> AVG_SH;
        endcase
        if (|res_s[IW-1:PIX_W]) begin
            y = '1;
        end else begin
            y = res_s[PIX_W-1:0];
        end
    end

endmodule

// File: rtl/intensity_window.sv
// Time-multiplexed RGB->intensity converter for a pixel window with a held, double-buffered result.
module intensity_window
    import intensity_pkg::*;
#(
    parameter int PIX_W   = 8,
    parameter int NUM_PIX = 9,
    parameter int LANES   = 3
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic                         intensity_enable,
    input  logic [1:0]                   mode,
    input  logic [3*PIX_W*NUM_PIX-1:0]   pixelData,
    input  logic                         edgedetect_enable,
    output logic                         busy,
    output logic                         iGrid_valid,
    output logic [PIX_W*NUM_PIX-1:0]     iGrid
);

    localparam int S      = NUM_PIX / LANES;
    localparam int STEP_W = (S > 1) ? $clog2(S) : 1;
    localparam int PW3    = 3 * PIX_W;

    state_t                       state_q, state_d;
    logic [STEP_W-1:0]            step_q, step_d;
    logic [PW3*NUM_PIX-1:0]       pix_q, pix_d;
    mode_t                        mode_q, mode_d;
    logic [PIX_W*NUM_PIX-1:0]     work_q, work_d;
    logic [PIX_W*NUM_PIX-1:0]     grid_q, grid_d;
    logic [PW3-1:0]               lane_pix_s [LANES];
    logic [PIX_W-1:0]             lane_y_s   [LANES];
    logic                         last_step_s;

    assign last_step_s = (step_q == STEP_W'(S - 1));

    // Route pixels step*LANES .. step*LANES+LANES-1 of the shadow window to the lanes.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_pix_s[l] = pix_q[(NUM_PIX - 1 - (int'(step_q) * LANES + l)) * PW3 +: PW3];
        end
    end

    for (genvar gl = 0; gl < LANES; gl++) begin : g_lane
        intensity_lane #(.PIX_W(PIX_W)) u_lane (
            .pix  (lane_pix_s[gl]),
            .mode (mode_q),
            .y    (lane_y_s[gl])
        );
    end

    // Next-state, shadow load, work-buffer fill and output-grid update.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        pix_d   = pix_q;
        mode_d  = mode_q;
        work_d  = work_q;
        grid_d  = grid_q;
        case (state_q)
            IDLE: begin
                if (intensity_enable) begin
                    pix_d   = pixelData;
                    mode_d  = decode_mode(mode);
                    step_d  = '0;
                    state_d = COMPUTE;
                end else begin
                    state_d = IDLE;
                end
            end
            COMPUTE: begin
                for (int l = 0; l < LANES; l++) begin
                    work_d[(NUM_PIX - 1 - (int'(step_q) * LANES + l)) * PIX_W +: PIX_W] = lane_y_s[l];
                end
                if (last_step_s) begin
                    grid_d  = work_d;
                    step_d  = '0;
                    state_d = DONE;
                end else begin
                    step_d  = step_q + STEP_W'(1);
                    state_d = COMPUTE;
                end
            end
            DONE: begin
                // A new start is honoured only together with the consumer's accept.
                if (edgedetect_enable) begin
                    if (intensity_enable) begin
                        pix_d   = pixelData;
                        mode_d  = decode_mode(mode);
                        step_d  = '0;
                        state_d = COMPUTE;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                step_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= IDLE;
            step_q  <= '0;
            pix_q   <= '0;
            mode_q  <= MODE_AVG;
            work_q  <= '0;
            grid_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            pix_q   <= pix_d;
            mode_q  <= mode_d;
            work_q  <= work_d;
            grid_q  <= grid_d;
        end
    end

    assign busy        = (state_q == COMPUTE);
    assign iGrid_valid = (state_q == DONE);
    assign iGrid       = grid_q;

endmodule

// File: tb/tb_intensity_window.sv
// Random + directed bench for intensity_window, with three lane-count variants fed identical stimulus.
module tb_intensity_window;

    logic         clk;
    logic         n_rst;
    logic         int_en;
    logic [1:0]   mode;
    logic [215:0] pixel_data;
    logic         ed_en;
    logic [71:0]  g1, g3, g9;
    logic         v1, v3, v9, b1, b3, b9;
    logic [71:0]  last_grid;
    int           tests;
    int           fails;

    localparam logic [215:0] DIR_PIX = {24'h141428, 24'h3C5064, {7{24'hFFFFFF}}};

    intensity_window #(.PIX_W(8), .NUM_PIX(9), .LANES(1)) dut1 (
        .clk(clk), .n_rst(n_rst), .intensity_enable(int_en), .mode(mode),
        .pixelData(pixel_data), .edgedetect_enable(ed_en),
        .busy(b1), .iGrid_valid(v1), .iGrid(g1));
    intensity_window #(.PIX_W(8), .NUM_PIX(9), .LANES(3)) dut3 (
        .clk(clk), .n_rst(n_rst), .intensity_enable(int_en), .mode(mode),
        .pixelData(pixel_data), .edgedetect_enable(ed_en),
        .busy(b3), .iGrid_valid(v3), .iGrid(g3));
    intensity_window #(.PIX_W(8), .NUM_PIX(9), .LANES(9)) dut9 (
        .clk(clk), .n_rst(n_rst), .intensity_enable(int_en), .mode(mode),
        .pixelData(pixel_data), .edgedetect_enable(ed_en),
        .busy(b9), .iGrid_valid(v9), .iGrid(g9));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [71:0] got, input logic [71:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Whole-window reference: every pixel converted directly from the arithmetic rules.
    function automatic logic [71:0] model(input logic [215:0] pix, input logic [1:0] m);
        logic [71:0] g;
        int r, gg, b, v;
        g = '0;
        for (int p = 0; p < 9; p++) begin
            r  = int'(pix[215 - 24*p -: 8]);
            gg = int'(pix[207 - 24*p -: 8]);
            b  = int'(pix[199 - 24*p -: 8]);
            case (m)
                2'b01:   v = (77*r + 150*gg + 29*b) / 256;
                2'b10:   v = (r > gg) ? ((r > b) ? r : b) : ((gg > b) ? gg : b);
                default: v = ((r + gg + b) * 683) / 2048;
            endcase
            if (v > 255) v = 255;
            g[71 - 8*p -: 8] = v[7:0];
        end
        return g;
    endfunction

    function automatic logic [215:0] rand_pix();
        logic [223:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[215:0];
    endfunction

    // Start a window, scramble inputs while computing, then check latency and grids on all variants.
    task automatic run_window(input logic [215:0] pix, input logic [1:0] m, input string tag);
        logic [71:0] exp;
        int lat1, lat3, lat9;
        exp = model(pix, m);
        pixel_data = pix;
        mode       = m;
        int_en     = 1'b1;
        tick();
        int_en     = 1'b0;
        pixel_data = rand_pix();
        mode       = 2'($urandom_range(0, 3));
        check_val({tag, ".busy"}, {69'd0, b1, b3, b9}, 72'd7);
        check_val({tag, ".prev"}, g3, last_grid);
        lat1 = 0; lat3 = 0; lat9 = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (v1 && lat1 == 0) lat1 = c;
            if (v3 && lat3 == 0) lat3 = c;
            if (v9 && lat9 == 0) lat9 = c;
        end
        check_val({tag, ".lat1"}, 72'(lat1), 72'd9);
        check_val({tag, ".lat3"}, 72'(lat3), 72'd3);
        check_val({tag, ".lat9"}, 72'(lat9), 72'd1);
        check_val({tag, ".g1"}, g1, exp);
        check_val({tag, ".g3"}, g3, exp);
        check_val({tag, ".g9"}, g9, exp);
        last_grid = exp;
    endtask

    task automatic accept(input string tag);
        ed_en = 1'b1;
        tick();
        ed_en = 1'b0;
        check_val({tag, ".acc"}, {66'd0, v1, v3, v9, b1, b3, b9}, 72'd0);
        check_val({tag, ".held"}, g3, last_grid);
    endtask

    initial begin
        tests = 0; fails = 0;
        n_rst = 1'b0; int_en = 1'b0; ed_en = 1'b0; mode = 2'b00; pixel_data = '0;
        last_grid = '0;
        tick(); tick();
        check_val("rst.grid", g3, 72'd0);
        check_val("rst.flags", {68'd0, v3, b3, v1, b1}, 72'd0);
        n_rst = 1'b1;
        tick();

        run_window(DIR_PIX, 2'b01, "luma");
        check_val("luma.const", g3, {8'd22, 8'd76, {7{8'hFF}}});
        accept("luma");
        run_window(DIR_PIX, 2'b00, "avg");
        check_val("avg.const", g3, {8'd26, 8'd80, {7{8'hFF}}});
        accept("avg");
        run_window(DIR_PIX, 2'b10, "max");
        check_val("max.const", g3, {8'd40, 8'd100, {7{8'hFF}}});

        // Start strobes in DONE without accept must not disturb the held result.
        for (int i = 0; i < 5; i++) begin
            int_en = 1'b1;
            pixel_data = rand_pix();
            mode = 2'($urandom_range(0, 3));
            tick();
            check_val("hold.g3", g3, {8'd40, 8'd100, {7{8'hFF}}});
            check_val("hold.v", {69'd0, v1, v3, v9}, 72'd7);
        end
        int_en = 1'b0;

        // Accept and restart on the same edge.
        pixel_data = '0; mode = 2'b10; int_en = 1'b1; ed_en = 1'b1;
        tick();
        int_en = 1'b0; ed_en = 1'b0;
        check_val("b2b.busy", {69'd0, b1, b3, b9}, 72'd7);
        tick(); tick(); tick();
        check_val("b2b.g3", g3, 72'd0);
        check_val("b2b.v3", {71'd0, v3}, 72'd1);
        for (int i = 0; i < 6; i++) tick();
        check_val("b2b.g1", g1, 72'd0);
        check_val("b2b.v1", {71'd0, v1}, 72'd1);
        last_grid = '0;
        accept("b2b");

        // Reset while computing discards the window.
        pixel_data = DIR_PIX; mode = 2'b01; int_en = 1'b1;
        tick();
        int_en = 1'b0;
        tick();
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
        check_val("midrst.grid", g3, 72'd0);
        check_val("midrst.g1", g1, 72'd0);
        check_val("midrst.flags", {66'd0, v1, v3, v9, b1, b3, b9}, 72'd0);
        last_grid = '0;
        run_window(rand_pix(), 2'($urandom_range(0, 3)), "postrst");
        accept("postrst");

        for (int n = 0; n < 16; n++) begin
            run_window(rand_pix(), 2'($urandom_range(0, 3)), "rand");
            accept("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
